// File: rtl/cache_axi_rd_arbiter.sv
// cache_axi_rd_arbiter
// Shares the single cache-to-AXI bridge read channel between the ICache
// (requester 0) and the DCache (requester 1). The DCache write channel passes
// straight through to the bridge.
//
// Once a requester is granted, the read channel belongs to it until the
// bridge returns the final beat (ret_valid & ret_last). Ties are broken by
// alternating away from the last granted requester.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_rd_* / i_ret_*         ICache read request / return
//   d_rd_* / d_ret_*         DCache read request / return
//   d_wr_*                   DCache write request (pass-through)
//   rd_*, rd_rdy             read request to the bridge
//   ret_valid/last/data      return beats from the bridge
//   wr_*, wr_rdy             write request to the bridge
//   cnt_i_rd, cnt_d_rd       wrapping counts of accepted ICache / DCache reads
module cache_axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_rd_req,
    input  logic [2:0]        i_rd_type,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              i_rd_rdy,
    output logic              i_ret_valid,
    output logic              i_ret_last,
    output logic [DATA_W-1:0] i_ret_data,

    input  logic              d_rd_req,
    input  logic [2:0]        d_rd_type,
    input  logic [ADDR_W-1:0] d_rd_addr,
    output logic              d_rd_rdy,
    output logic              d_ret_valid,
    output logic              d_ret_last,
    output logic [DATA_W-1:0] d_ret_data,

    input  logic              d_wr_req,
    input  logic [2:0]        d_wr_type,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [3:0]        d_wr_wstrb,
    input  logic [127:0]      d_wr_data,
    output logic              d_wr_rdy,

    output logic              rd_req,
    output logic [2:0]        rd_type,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_rdy,
    input  logic              ret_valid,
    input  logic              ret_last,
    input  logic [DATA_W-1:0] ret_data,

    output logic              wr_req,
    output logic [2:0]        wr_type,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        wr_wstrb,
    output logic [127:0]      wr_data,
    input  logic              wr_rdy,

    output logic [CNT_W-1:0]  cnt_i_rd,
    output logic [CNT_W-1:0]  cnt_d_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   owner, owner_nxt;           // 0 = ICache, 1 = DCache
    logic   last_grant, last_grant_nxt;
    logic   inc_i, inc_d;

    // Arbitration: a lone requester wins; on a tie the requester that was
    // not granted last time wins.
    logic              any_req;
    logic              winner;
    logic              sel;
    logic              sel_req;
    logic [2:0]        sel_type;
    logic [ADDR_W-1:0] sel_addr;

    assign any_req  = i_rd_req | d_rd_req;
    assign winner   = (i_rd_req & d_rd_req) ? ~last_grant : d_rd_req;
    // In HOLD the choice is frozen to the registered owner.
    assign sel      = (state == IDLE) ? winner : owner;
    assign sel_req  = sel ? d_rd_req  : i_rd_req;
    assign sel_type = sel ? d_rd_type : i_rd_type;
    assign sel_addr = sel ? d_rd_addr : i_rd_addr;

    // Write channel is independent of the read state machine.
    assign wr_req   = d_wr_req;
    assign wr_type  = d_wr_type;
    assign wr_addr  = d_wr_addr;
    assign wr_wstrb = d_wr_wstrb;
    assign wr_data  = d_wr_data;
    assign d_wr_rdy = wr_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;   // makes the ICache win the first tie
            cnt_i_rd   <= '0;
            cnt_d_rd   <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            if (inc_i) cnt_i_rd <= cnt_i_rd + CNT_W'(1);
            if (inc_d) cnt_d_rd <= cnt_d_rd + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        inc_i          = 1'b0;
        inc_d          = 1'b0;
        rd_req         = 1'b0;
        rd_type        = 3'd0;
        rd_addr        = '0;
        i_rd_rdy       = 1'b0;
        d_rd_rdy       = 1'b0;
        i_ret_valid    = 1'b0;
        i_ret_last     = 1'b0;
        i_ret_data     = '0;
        d_ret_valid    = 1'b0;
        d_ret_last     = 1'b0;
        d_ret_data     = '0;

        case (state)
            IDLE: begin
                if (any_req) begin
                    rd_req    = 1'b1;
                    rd_type   = sel_type;
                    rd_addr   = sel_addr;
                    owner_nxt = winner;
                    if (winner) d_rd_rdy = rd_rdy;
                    else        i_rd_rdy = rd_rdy;
                    if (rd_rdy) begin
                        state_nxt      = WAIT;
                        last_grant_nxt = winner;
                        inc_i          = ~winner;
                        inc_d          = winner;
                    end else begin
                        state_nxt = HOLD;
                    end
                end
            end

            HOLD: begin
                if (sel_req) begin
                    rd_req  = 1'b1;
                    rd_type = sel_type;
                    rd_addr = sel_addr;
                    if (owner) d_rd_rdy = rd_rdy;
                    else       i_rd_rdy = rd_rdy;
                    if (rd_rdy) begin
                        state_nxt      = WAIT;
                        last_grant_nxt = owner;
                        inc_i          = ~owner;
                        inc_d          = owner;
                    end
                end else begin
                    // Owner withdrew before acceptance; nothing was issued.
                    state_nxt = IDLE;
                end
            end

            WAIT: begin
                if (owner) begin
                    d_ret_valid = ret_valid;
                    d_ret_last  = ret_last;
                    d_ret_data  = ret_data;
                end else begin
                    i_ret_valid = ret_valid;
                    i_ret_last  = ret_last;
                    i_ret_data  = ret_data;
                end
                if (ret_valid && ret_last) state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase

        // Keep the read side quiet while reset is held.
        if (rst) begin
            rd_req      = 1'b0;
            rd_type     = 3'd0;
            rd_addr     = '0;
            i_rd_rdy    = 1'b0;
            d_rd_rdy    = 1'b0;
            i_ret_valid = 1'b0;
            i_ret_last  = 1'b0;
            i_ret_data  = '0;
            d_ret_valid = 1'b0;
            d_ret_last  = 1'b0;
            d_ret_data  = '0;
            inc_i       = 1'b0;
            inc_d       = 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Directed bench for cache_axi_rd_arbiter: grant, tie alternation, line
// returns, HOLD behaviour, write pass-through and reset during WAIT.
module tb_cache_axi_rd_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_rd_req;
    logic [2:0]   i_rd_type;
    logic [31:0]  i_rd_addr;
    logic         i_rd_rdy, i_ret_valid, i_ret_last;
    logic [31:0]  i_ret_data;
    logic         d_rd_req;
    logic [2:0]   d_rd_type;
    logic [31:0]  d_rd_addr;
    logic         d_rd_rdy, d_ret_valid, d_ret_last;
    logic [31:0]  d_ret_data;
    logic         d_wr_req;
    logic [2:0]   d_wr_type;
    logic [31:0]  d_wr_addr;
    logic [3:0]   d_wr_wstrb;
    logic [127:0] d_wr_data;
    logic         d_wr_rdy;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy, ret_valid, ret_last;
    logic [31:0]  ret_data;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;
    logic [31:0]  cnt_i_rd, cnt_d_rd;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cache_axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr),
        .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last),
        .i_ret_data(i_ret_data),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr),
        .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last),
        .d_ret_data(d_ret_data),
        .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr),
        .d_wr_wstrb(d_wr_wstrb), .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy),
        .cnt_i_rd(cnt_i_rd), .cnt_d_rd(cnt_d_rd)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge; inputs are driven here and
    // checks follow after a short settle delay, well before the next edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        i_rd_req = 0; i_rd_type = 0; i_rd_addr = 0;
        d_rd_req = 0; d_rd_type = 0; d_rd_addr = 0;
        d_wr_req = 0; d_wr_type = 0; d_wr_addr = 0; d_wr_wstrb = 0; d_wr_data = 0;
        rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = 0; wr_rdy = 0;
    endtask

    logic exp_d_win [4];

    initial begin
        exp_d_win[0] = 1'b0; exp_d_win[1] = 1'b1;
        exp_d_win[2] = 1'b0; exp_d_win[3] = 1'b1;
        clear_inputs();
        rst = 1;

        // ---- reset: read side silent, write side passes through ----
        cyc();
        i_rd_req = 1; i_rd_addr = 32'h0000_1000; rd_rdy = 1;
        d_wr_req = 1; wr_rdy = 1;
        #1;
        chk("rst_rd_req",   rd_req,   0);
        chk("rst_i_rdy",    i_rd_rdy, 0);
        chk("rst_cnt_i",    cnt_i_rd, 0);
        chk("rst_cnt_d",    cnt_d_rd, 0);
        chk("rst_wr_req",   wr_req,   1);
        chk("rst_d_wr_rdy", d_wr_rdy, 1);
        cyc();
        clear_inputs(); rst = 0;

        // ---- ICache word read, single beat ----
        cyc();
        i_rd_req = 1; i_rd_type = 3'b010; i_rd_addr = 32'h1C00_0000; rd_rdy = 1;
        #1;
        chk("t1_rd_req",  rd_req,   1);
        chk("t1_rd_addr", rd_addr,  32'h1C00_0000);
        chk("t1_rd_type", rd_type,  3'b010);
        chk("t1_i_rdy",   i_rd_rdy, 1);
        chk("t1_d_rdy",   d_rd_rdy, 0);
        cyc();
        clear_inputs();
        ret_valid = 1; ret_last = 1; ret_data = 32'hDEAD_BEEF;
        #1;
        chk("t1_i_ret_valid", i_ret_valid, 1);
        chk("t1_i_ret_last",  i_ret_last,  1);
        chk("t1_i_ret_data",  i_ret_data,  32'hDEAD_BEEF);
        chk("t1_d_ret_valid", d_ret_valid, 0);
        chk("t1_d_ret_data",  d_ret_data,  0);
        chk("t1_wait_rd_req", rd_req,      0);
        chk("t1_cnt_i",       cnt_i_rd,    1);
        cyc();
        clear_inputs();
        rst = 1;
        cyc();
        rst = 0;

        // ---- four contested rounds: I, D, I, D ----
        for (int r = 0; r < 4; r++) begin
            cyc();
            clear_inputs();
            i_rd_req = 1; i_rd_addr = 32'h0000_0100; i_rd_type = 3'b010;
            d_rd_req = 1; d_rd_addr = 32'h0000_0200; d_rd_type = 3'b010;
            rd_rdy = 1;
            #1;
            chk($sformatf("t2_r%0d_i_rdy", r), i_rd_rdy, !exp_d_win[r]);
            chk($sformatf("t2_r%0d_d_rdy", r), d_rd_rdy, exp_d_win[r]);
            chk($sformatf("t2_r%0d_addr", r), rd_addr,
                exp_d_win[r] ? 32'h0000_0200 : 32'h0000_0100);
            cyc();
            rd_rdy = 0; ret_valid = 1; ret_last = 1; ret_data = 32'h1000 + r;
            #1;
            chk($sformatf("t2_r%0d_i_ret", r), i_ret_valid, !exp_d_win[r]);
            chk($sformatf("t2_r%0d_d_ret", r), d_ret_valid, exp_d_win[r]);
            chk($sformatf("t2_r%0d_req0", r), rd_req, 0);
        end
        cyc();
        clear_inputs();
        #1;
        chk("t2_cnt_i", cnt_i_rd, 2);
        chk("t2_cnt_d", cnt_d_rd, 2);

        // ---- DCache 4-beat line read, ICache waiting ----
        cyc();
        d_rd_req = 1; d_rd_type = 3'b100; d_rd_addr = 32'h0000_2000; rd_rdy = 1;
        #1;
        chk("t3_d_rdy",   d_rd_rdy, 1);
        chk("t3_rd_type", rd_type,  3'b100);
        for (int b = 0; b < 4; b++) begin
            cyc();
            clear_inputs();
            i_rd_req = 1; i_rd_addr = 32'h0000_3000; rd_rdy = 1;
            ret_valid = 1; ret_last = (b == 3); ret_data = 32'hA0 + b;
            #1;
            chk($sformatf("t3_b%0d_d_valid", b), d_ret_valid, 1);
            chk($sformatf("t3_b%0d_d_data", b), d_ret_data, 32'hA0 + b);
            chk($sformatf("t3_b%0d_d_last", b), d_ret_last, b == 3);
            chk($sformatf("t3_b%0d_i_rdy", b), i_rd_rdy, 0);
            chk($sformatf("t3_b%0d_i_valid", b), i_ret_valid, 0);
        end
        cyc();
        ret_valid = 0; ret_last = 0; ret_data = 0;
        #1;
        chk("t3_i_rdy_after", i_rd_rdy, 1);
        chk("t3_cnt_d",       cnt_d_rd, 3);
        cyc();
        clear_inputs();
        ret_valid = 1; ret_last = 1;
        #1;
        chk("t3_i_ret", i_ret_valid, 1);

        // ---- DCache held in HOLD for 3 cycles while ICache asserts ----
        // last grant was ICache, so the tie goes to DCache
        for (int c = 0; c < 3; c++) begin
            cyc();
            clear_inputs();
            i_rd_req = 1; i_rd_addr = 32'h0000_0400;
            d_rd_req = 1; d_rd_addr = 32'h0000_0300; d_rd_type = 3'b010;
            #1;
            chk($sformatf("t4_c%0d_addr", c), rd_addr, 32'h0000_0300);
            chk($sformatf("t4_c%0d_d_rdy", c), d_rd_rdy, 0);
            chk($sformatf("t4_c%0d_i_rdy", c), i_rd_rdy, 0);
        end
        cyc();
        rd_rdy = 1;
        #1;
        chk("t4_accept_d_rdy", d_rd_rdy, 1);
        chk("t4_accept_i_rdy", i_rd_rdy, 0);
        chk("t4_accept_addr",  rd_addr,  32'h0000_0300);
        cyc();
        clear_inputs();
        ret_valid = 1; ret_last = 1;
        #1;
        chk("t4_cnt_d",   cnt_d_rd,    4);
        chk("t4_d_ret",   d_ret_valid, 1);

        // ---- DCache write during ICache WAIT ----
        cyc();
        clear_inputs();
        i_rd_req = 1; i_rd_addr = 32'h0000_0500; rd_rdy = 1;
        cyc();
        clear_inputs();
        d_wr_req = 1; d_wr_type = 3'b010; d_wr_addr = 32'h8000_0010;
        d_wr_wstrb = 4'hF; d_wr_data = 128'h1234_5678; wr_rdy = 1;
        ret_valid = 1; ret_last = 1; ret_data = 32'h55;
        #1;
        chk("t5_wr_req",   wr_req,      1);
        chk("t5_wr_type",  wr_type,     3'b010);
        chk("t5_wr_addr",  wr_addr,     32'h8000_0010);
        chk("t5_wr_wstrb", wr_wstrb,    4'hF);
        chk("t5_wr_data",  wr_data,     128'h1234_5678);
        chk("t5_d_wr_rdy", d_wr_rdy,    1);
        chk("t5_i_ret",    i_ret_valid, 1);
        chk("t5_i_data",   i_ret_data,  32'h55);
        chk("t5_d_ret",    d_ret_valid, 0);
        chk("t5_cnt_i",    cnt_i_rd,    4);
        wr_rdy = 0;
        #1;
        chk("t5_d_wr_rdy0", d_wr_rdy, 0);

        // ---- reset pulsed in WAIT, stale return dropped ----
        cyc();
        clear_inputs();
        i_rd_req = 1; i_rd_addr = 32'h0000_0600; rd_rdy = 1;
        cyc();
        clear_inputs();
        rst = 1;
        cyc();
        rst = 0;
        ret_valid = 1; ret_last = 1; ret_data = 32'h77;
        #1;
        chk("t6_i_ret",   i_ret_valid, 0);
        chk("t6_d_ret",   d_ret_valid, 0);
        chk("t6_i_data",  i_ret_data,  0);
        chk("t6_cnt_i",   cnt_i_rd,    0);
        chk("t6_cnt_d",   cnt_d_rd,    0);
        cyc();
        clear_inputs();
        i_rd_req = 1; i_rd_addr = 32'h0000_0700; rd_rdy = 1;
        #1;
        chk("t6_idle_i_rdy", i_rd_rdy, 1);
        cyc();
        clear_inputs();
        #1;
        chk("t6_cnt_i_after", cnt_i_rd, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
